// File: rtl/fsm_rd_param_s.sv
// fsm_rd_param_s: table-driven Moore machine with twin ("dup") states.
// A writable next-state table (NT) selects the successor of each state per
// input value, and a writable output table (OT) supplies rtext for every
// {state, dup} pair. A self-loop toggles dup instead of changing state.
// An out-of-range successor latches a sticky err and forces rtext to ones.
// Optional build macro: SFSM_PARITY_EN adds a parity bit over {state, dup}.
module fsm_rd_param_s #(
  parameter int IN_W  = 2,
  parameter int OUT_W = 8,
  parameter int NST   = 20,
  parameter int SW    = 5
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 en,
  input  logic [IN_W-1:0]      ptext,
  input  logic                 cfg_we,
  input  logic                 cfg_sel,
  input  logic [SW+IN_W-1:0]   cfg_addr,
  input  logic [OUT_W-1:0]     cfg_data,
  output logic [OUT_W-1:0]     rtext,
  output logic [SW-1:0]        state_o,
  output logic                 dup_o,
  output logic                 err
);

  localparam int NT_N = NST * (2 ** IN_W);
  localparam int OT_N = NST * 2;
  // One extra bit so that NST == 2^SW is still representable.
  localparam logic [SW:0] NST_V = NST[SW:0];

  logic [SW-1:0]    nt_q [NT_N];
  logic [SW-1:0]    nt_d [NT_N];
  logic [OUT_W-1:0] ot_q [OT_N];
  logic [OUT_W-1:0] ot_d [OT_N];

  logic [SW-1:0] state_q, state_d;
  logic          dup_q, dup_d;
  logic          err_q, err_d;

  logic [SW-1:0] nxt;
  logic          nxt_bad;
  logic [SW-1:0] nt_wr_state;
  logic [SW-1:0] ot_wr_state;

`ifdef SFSM_PARITY_EN
  logic par_q, par_d;
`endif

  // Table writes; entries whose state field is out of range are dropped.
  always_comb begin
    nt_d        = nt_q;
    ot_d        = ot_q;
    nt_wr_state = cfg_addr[SW+IN_W-1:IN_W];
    ot_wr_state = cfg_addr[SW:1];
    if (cfg_we) begin
      if (!cfg_sel) begin
        if ({1'b0, nt_wr_state} < NST_V) begin
          nt_d[cfg_addr] = cfg_data[SW-1:0];
        end
      end else begin
        if ({1'b0, ot_wr_state} < NST_V) begin
          ot_d[cfg_addr[SW:0]] = cfg_data;
        end
      end
    end
  end

  // Transition logic; reads the registered (pre-write) next-state table.
  always_comb begin
    nxt     = nt_q[{state_q, ptext}];
    nxt_bad = ({1'b0, nxt} >= NST_V);
    state_d = state_q;
    dup_d   = dup_q;
    err_d   = err_q;
    if (en && !err_q) begin
      if (nxt_bad) begin
        err_d = 1'b1;
      end else if (nxt == state_q) begin
        dup_d = ~dup_q;
      end else begin
        state_d = nxt;
        dup_d   = 1'b0;
      end
    end
`ifdef SFSM_PARITY_EN
    // Parity always tracks the value being loaded, so it follows every update.
    par_d = ^{state_d, dup_d};
    if ((^{state_q, dup_q}) != par_q) begin
      err_d = 1'b1;
    end
`endif
  end

  // State, flag and table registers with asynchronous clear.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= '0;
      dup_q   <= 1'b0;
      err_q   <= 1'b0;
      for (int unsigned i = 0; i < NT_N; i++) nt_q[i] <= '0;
      for (int unsigned j = 0; j < OT_N; j++) ot_q[j] <= '0;
    end else begin
      state_q <= state_d;
      dup_q   <= dup_d;
      err_q   <= err_d;
      for (int unsigned i = 0; i < NT_N; i++) nt_q[i] <= nt_d[i];
      for (int unsigned j = 0; j < OT_N; j++) ot_q[j] <= ot_d[j];
    end
  end

`ifdef SFSM_PARITY_EN
  // Parity register; {0, 0} has even parity so it clears to 0.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) par_q <= 1'b0;
    else     par_q <= par_d;
  end
`endif

  // Moore output straight from the registered state, masked by the fault.
  always_comb begin
    rtext = err_q ? '1 : ot_q[{state_q, dup_q}];
  end

  assign state_o = state_q;
  assign dup_o   = dup_q;
  assign err     = err_q;

endmodule

// File: tb/tb_fsm_rd_param_s.sv
// Self-checking bench for fsm_rd_param_s: directed scenarios plus a
// randomized run compared against a table-level behavioural model.
module tb_fsm_rd_param_s;

  localparam int IN_W  = 2;
  localparam int OUT_W = 8;
  localparam int NST   = 20;
  localparam int SW    = 5;
  localparam int NI    = 1 << IN_W;

  logic               CLK = 1'b0;
  logic               RST = 1'b0;
  logic               en = 1'b0;
  logic [IN_W-1:0]    ptext = '0;
  logic               cfg_we = 1'b0;
  logic               cfg_sel = 1'b0;
  logic [SW+IN_W-1:0] cfg_addr = '0;
  logic [OUT_W-1:0]   cfg_data = '0;
  logic [OUT_W-1:0]   rtext;
  logic [SW-1:0]      state_o;
  logic               dup_o;
  logic               err;

  int total = 0;
  int bad   = 0;

  // Behavioural model: plain integer tables indexed state*inputs+input.
  int nt_m [NST*NI];
  int ot_m [NST*2];
  int s_m, dup_m, err_m;

  fsm_rd_param_s #(.IN_W(IN_W), .OUT_W(OUT_W), .NST(NST), .SW(SW)) dut (
    .CLK(CLK), .RST(RST), .en(en), .ptext(ptext), .cfg_we(cfg_we),
    .cfg_sel(cfg_sel), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .rtext(rtext), .state_o(state_o), .dup_o(dup_o), .err(err)
  );

  always #5 CLK = ~CLK;

  function automatic int exp_rtext();
    return (err_m != 0) ? 255 : ot_m[s_m*2 + dup_m];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NST*NI; i++) nt_m[i] = 0;
    for (int i = 0; i < NST*2; i++) ot_m[i] = 0;
    s_m = 0; dup_m = 0; err_m = 0;
  endtask

  // Drive one clock cycle of stimulus and advance the model by the same edge.
  task automatic cyc(input int e, input int p, input int we, input int sel,
                     input int addr, input int data);
    int n, st;
    en = e[0]; ptext = p[IN_W-1:0]; cfg_we = we[0]; cfg_sel = sel[0];
    cfg_addr = addr[SW+IN_W-1:0]; cfg_data = data[OUT_W-1:0];
    if (e != 0 && err_m == 0) begin
      n = nt_m[s_m*NI + (p % NI)];
      if (n >= NST) err_m = 1;
      else if (n == s_m) dup_m = 1 - dup_m;
      else begin s_m = n; dup_m = 0; end
    end
    if (we != 0) begin
      if (sel == 0) begin
        st = addr / NI;
        if (st < NST) nt_m[addr] = data % (1 << SW);
      end else begin
        st = (addr % 64) / 2;
        if (st < NST) ot_m[addr % 64] = data % 256;
      end
    end
    @(posedge CLK); #1;
    en = 1'b0; cfg_we = 1'b0;
  endtask

  task automatic wr_nt(input int st, input int in, input int val);
    cyc(0, 0, 1, 0, st*NI + in, val);
  endtask

  task automatic wr_ot(input int st, input int d, input int val);
    cyc(0, 0, 1, 1, st*2 + d, val);
  endtask

  // Assert RST away from the edge; a write presented during reset must be lost.
  task automatic apply_reset();
    RST = 1'b1;
    model_clear();
    #1;
    cfg_we = 1'b1; cfg_sel = 1'b1; cfg_addr = '0; cfg_data = 8'hAA;
    en = 1'b1;
    @(posedge CLK); #3;
    RST = 1'b0; cfg_we = 1'b0; en = 1'b0;
    @(posedge CLK); #1;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    #2;
    total++; if (rtext !== 8'h00) begin bad++; $display("FAIL reset_rtext_during got=%h want=00", rtext); end
    total++; if (state_o !== 5'd0) begin bad++; $display("FAIL reset_state_during got=%0d want=0", state_o); end
    apply_reset();
    total++; if (rtext !== 8'h00) begin bad++; $display("FAIL reset_rtext_after got=%h want=00", rtext); end
    total++; if (dup_o !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL reset_flags got=%b%b want=00", dup_o, err); end
  endtask

  task automatic test_basic();
    wr_nt(0, 0, 1);
    wr_nt(0, 1, 2);
    wr_ot(1, 0, 8'h3B);
    total++; if (state_o !== 5'd0) begin bad++; $display("FAIL basic_hold got=%0d want=0", state_o); end
    cyc(1, 0, 0, 0, 0, 0);
    total++; if (state_o !== 5'd1) begin bad++; $display("FAIL basic_state got=%0d want=1", state_o); end
    total++; if (rtext !== 8'h3B) begin bad++; $display("FAIL basic_rtext got=%h want=3B", rtext); end
  endtask

  task automatic test_dup();
    logic [7:0] want [3];
    want[0] = 8'hE3; want[1] = 8'hC3; want[2] = 8'hE3;
    wr_nt(1, 0, 15);
    wr_nt(15, 0, 15);
    wr_ot(15, 0, 8'hE3);
    wr_ot(15, 1, 8'hC3);
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (rtext !== want[i] || state_o !== 5'd15 || dup_o !== logic'(i % 2)) begin
        bad++;
        $display("FAIL dup_toggle[%0d] got=%h/%0d/%b want=%h/15/%0d", i, rtext, state_o, dup_o, want[i], i % 2);
      end
      if (i < 2) cyc(1, 0, 0, 0, 0, 0);
    end
    cyc(1, 0, 0, 0, 0, 0);
  endtask

  task automatic test_dup_exit();
    wr_nt(15, 1, 16);
    total++; if (dup_o !== 1'b1) begin bad++; $display("FAIL dup_exit_pre got=%b want=1", dup_o); end
    cyc(1, 1, 0, 0, 0, 0);
    total++; if (state_o !== 5'd16 || dup_o !== 1'b0) begin bad++; $display("FAIL dup_exit got=%0d/%b want=16/0", state_o, dup_o); end
  endtask

  task automatic test_write_collision();
    wr_nt(16, 0, 3);
    wr_nt(3, 1, 4);
    wr_nt(4, 1, 3);
    cyc(1, 0, 0, 0, 0, 0);
    total++; if (state_o !== 5'd3) begin bad++; $display("FAIL coll_setup got=%0d want=3", state_o); end
    cyc(1, 1, 1, 0, 3*NI + 1, 7);
    total++; if (state_o !== 5'd4) begin bad++; $display("FAIL coll_old_entry got=%0d want=4", state_o); end
    cyc(1, 1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    total++; if (state_o !== 5'd7) begin bad++; $display("FAIL coll_new_entry got=%0d want=7", state_o); end
  endtask

  task automatic test_fault();
    wr_nt(7, 2, 25);
    wr_nt(NST + 1, 0, 9);
    cyc(1, 2, 0, 0, 0, 0);
    total++; if (err !== 1'b1 || rtext !== 8'hFF) begin bad++; $display("FAIL fault_set got=%b/%h want=1/FF", err, rtext); end
    total++; if (state_o !== 5'd7) begin bad++; $display("FAIL fault_state got=%0d want=7", state_o); end
    for (int i = 0; i < 4; i++) cyc(1, i, 0, 0, 0, 0);
    total++; if (state_o !== 5'd7 || err !== 1'b1) begin bad++; $display("FAIL fault_sticky got=%0d/%b want=7/1", state_o, err); end
    apply_reset();
    total++; if (err !== 1'b0 || state_o !== 5'd0) begin bad++; $display("FAIL fault_clear got=%b/%0d want=0/0", err, state_o); end
  endtask

  task automatic test_random();
    int kind, st, v;
    for (int c = 0; c < 600; c++) begin
      kind = int'($urandom_range(0, 9));
      st = int'($urandom_range(0, 23));
      if (kind < 3) begin
        v = ($urandom_range(0, 39) == 0) ? int'($urandom_range(NST, 31)) : int'($urandom_range(0, NST-1));
        v = v + 32 * int'($urandom_range(0, 7));
        cyc(int'($urandom_range(0, 1)), int'($urandom_range(0, NI-1)), 1, 0,
            st*NI + int'($urandom_range(0, NI-1)), v);
      end else if (kind < 5) begin
        cyc(int'($urandom_range(0, 1)), int'($urandom_range(0, NI-1)), 1, 1,
            64*int'($urandom_range(0, 1)) + st*2 + int'($urandom_range(0, 1)),
            int'($urandom_range(0, 255)));
      end else begin
        cyc(int'($urandom_range(0, 3) != 0), int'($urandom_range(0, NI-1)), 0, 0, 0, 0);
      end
      total++;
      if (rtext !== OUT_W'(exp_rtext()) || state_o !== SW'(s_m) ||
          dup_o !== logic'(dup_m) || err !== logic'(err_m)) begin
        bad++;
        $display("FAIL random[%0d] got=%h/%0d/%b/%b want=%h/%0d/%0d/%0d",
                 c, rtext, state_o, dup_o, err, exp_rtext(), s_m, dup_m, err_m);
      end
      if (err_m != 0 && $urandom_range(0, 7) == 0) apply_reset();
    end
  endtask

  initial begin
    model_clear();
    #3;
    test_reset();
    test_basic();
    test_dup();
    test_dup_exit();
    test_write_collision();
    test_fault();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
